// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: lights eight lamps one per tick, then hands a pseudo-random count to the delay block.
// Optional build macro F1_MIN_DELAY_EN floors the latched delay_n at MIN_DELAY.
//
// state   | meaning
// IDLE    | lamps off, waiting for trigger
// LIGHTS  | one lamp added per tick, eight in total
// ARM     | single cycle, cmd_delay pulse to the delay block
// WAIT_TO | all lamps on until time_out returns
// RELEASE | lamps off, waiting for the trigger switch to open
module f1_light_seq #(
    parameter int WIDTH     = 7,
    parameter int MIN_DELAY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             tick,
    input  logic             time_out,
    output logic [7:0]       data_out,
    output logic             cmd_delay,
    output logic [WIDTH-1:0] delay_n,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LIGHTS  = 3'd1,
        ARM     = 3'd2,
        WAIT_TO = 3'd3,
        RELEASE = 3'd4
    } state_t;

`ifdef F1_MIN_DELAY_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_DELAY);

    state_t           state, state_nxt;
    logic [7:0]       data_nxt;
    logic [2:0]       count, count_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_floor, delay_nxt;

    // With the floor disabled MIN_EN is 0 and this collapses to the raw LFSR.
    assign lfsr_floor = (MIN_EN && (lfsr < MIN_W)) ? MIN_W : lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            data_out <= 8'h00;
            count    <= 3'd0;
            delay_n  <= WIDTH'(1);
            lfsr     <= WIDTH'(1);
        end else begin
            state    <= state_nxt;
            data_out <= data_nxt;
            count    <= count_nxt;
            delay_n  <= delay_nxt;
            lfsr     <= {lfsr[WIDTH-2:0], lfsr[6] ^ lfsr[5]};
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        count_nxt = count;
        delay_nxt = delay_n;
        case (state)
            IDLE: begin
                data_nxt  = 8'h00;
                count_nxt = 3'd0;
                if (trigger) state_nxt = LIGHTS;
            end
            LIGHTS: begin
                if (tick) begin
                    data_nxt  = {data_out[6:0], 1'b1};
                    count_nxt = count + 3'd1;
                    if (count == 3'd7) begin
                        state_nxt = ARM;
                        delay_nxt = lfsr_floor;
                    end
                end
            end
            ARM: begin
                data_nxt  = 8'hFF;
                state_nxt = WAIT_TO;
            end
            WAIT_TO: begin
                data_nxt = 8'hFF;
                if (time_out) begin
                    data_nxt  = 8'h00;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                data_nxt = 8'h00;
                // A held switch must be released before a new start is accepted.
                if (!trigger) state_nxt = IDLE;
            end
            default: begin
                data_nxt  = 8'h00;
                count_nxt = 3'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_delay = (state == ARM);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: a behavioural lamp/LFSR model pushes expected outputs per edge, compared at the falling edge.
module tb_f1_light_seq;
    localparam int WIDTH     = 7;
    localparam int MIN_DELAY = 16;

    logic clk = 1'b0, rst = 1'b0, trigger = 1'b0, tick = 1'b0, time_out = 1'b0;
    logic [7:0]       data_out;
    logic             cmd_delay;
    logic [WIDTH-1:0] delay_n;
    logic             busy;

    f1_light_seq #(.WIDTH(WIDTH), .MIN_DELAY(MIN_DELAY)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .time_out(time_out),
        .data_out(data_out), .cmd_delay(cmd_delay), .delay_n(delay_n), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       cmd;
        logic [6:0] dn;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    int m_phase, m_lamps;
    logic [6:0] m_lfsr, m_dn;
    int cmd_seen, steps;
    logic [7:0] prev_data;

`ifdef F1_MIN_DELAY_EN
    localparam logic [6:0] EXP_DN1 = 7'h10;
`else
    localparam logic [6:0] EXP_DN1 = 7'h06;
`endif

    function automatic logic [6:0] floor_min(input logic [6:0] v);
`ifdef F1_MIN_DELAY_EN
        return (v < 7'(MIN_DELAY)) ? 7'(MIN_DELAY) : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    function automatic logic [6:0] lfsr_adv8(input logic [6:0] v);
        logic [6:0] r;
        r = v;
        for (int k = 0; k < 8; k++) r = lfsr_step(r);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_lamps = 0; m_lfsr = 7'h01; m_dn = 7'h01;
        sb.delete();
    endtask

    task automatic model_edge(input logic trg, input logic tk, input logic to);
        exp_t e;
        case (m_phase)
            0: if (trg) begin m_phase = 1; m_lamps = 0; end
            1: if (tk) begin
                   m_lamps++;
                   if (m_lamps == 8) begin m_phase = 2; m_dn = floor_min(m_lfsr); end
               end
            2: m_phase = 3;
            3: if (to) m_phase = 4;
            default: if (!trg) m_phase = 0;
        endcase
        m_lfsr = lfsr_step(m_lfsr);
        e.data = (m_phase >= 1 && m_phase <= 3) ? 8'((1 << m_lamps) - 1) : 8'h00;
        e.cmd  = (m_phase == 2);
        e.dn   = m_dn;
        e.busy = (m_phase != 0);
        sb.push_back(e);
    endtask

    task automatic cycle(input logic trg, input logic tk, input logic to, input string tag);
        exp_t e;
        trigger = trg; tick = tk; time_out = to;
        @(posedge clk);
        model_edge(trg, tk, to);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".data"}, data_out, e.data);
        check({tag, ".cmd"}, cmd_delay, e.cmd);
        check({tag, ".dn"}, delay_n, e.dn);
        check({tag, ".busy"}, busy, e.busy);
        if (cmd_delay === 1'b1) cmd_seen++;
        if (data_out !== prev_data) steps++;
        prev_data = data_out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    logic [6:0] dn_run [3];
    int wait_cnt, guard;
    logic done, to_v;

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.data", data_out, 8'h00);
        check("rst.cmd", cmd_delay, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.dn", delay_n, 7'h01);
        model_reset();
        prev_data = 8'h00;
        rst = 1'b1;

        // Full sequence, tick tied high; the tick on the trigger edge is not counted.
        cmd_seen = 0; steps = 0;
        cycle(1, 1, 0, "full_trig");
        repeat (8) cycle(1, 1, 0, "full");
        check("full.steps", steps, 8);
        check("full.dn_value", delay_n, EXP_DN1);
        check("full.arm_ff", data_out, 8'hFF);
        cycle(0, 1, 0, "wait_ign");
        cycle(1, 0, 0, "wait_ign");
        cycle(0, 1, 0, "wait_ign");
        cycle(1, 1, 0, "wait_ign");
        check("full.cmd_once", cmd_seen, 1);
        cycle(1, 0, 1, "done");
        check("done.off", data_out, 8'h00);
        cycle(1, 0, 0, "release_hold");
        cycle(1, 0, 0, "release_hold");
        check("release.busy", busy, 1'b1);
        cycle(0, 0, 0, "to_idle");
        check("idle.busy", busy, 1'b0);
        cycle(0, 1, 1, "idle_stray");

        // Sparse ticks with stray time_out pulses, including on the final tick and in ARM.
        cmd_seen = 0; steps = 0;
        cycle(1, 0, 0, "sparse_trig");
        for (int i = 0; i < 32; i++) cycle(0, (i % 4) == 3, (i % 5) == 1, "sparse");
        check("sparse.steps", steps, 8);
        cycle(0, 0, 1, "arm_stray");
        cycle(0, 0, 0, "sparse_wait");
        cycle(0, 0, 0, "sparse_wait");
        check("sparse.cmd_once", cmd_seen, 1);
        check("sparse.hold_ff", data_out, 8'hFF);

        // Asynchronous reset in WAIT_TO, observed before the next rising edge.
        #2 rst = 1'b0;
        #1;
        check("arst.data", data_out, 8'h00);
        check("arst.cmd", cmd_delay, 1'b0);
        check("arst.busy", busy, 1'b0);
        check("arst.dn", delay_n, 7'h01);
        model_reset();
        @(negedge clk);
        prev_data = 8'h00;
        rst = 1'b1;

        // Closed loop with a delay-block model: time_out arrives delay_n+1 cycles after cmd_delay.
        for (int run = 0; run < 3; run++) begin
            guard = 0;
            if (run > 0) begin
                while (floor_min(lfsr_adv8(m_lfsr)) == dn_run[run-1] && guard < 200) begin
                    cycle(0, 0, 0, "gap");
                    guard++;
                end
            end
            cmd_seen = 0; wait_cnt = 0; done = 1'b0;
            cycle(1, 1, 0, "loop_trig");
            for (int c = 0; c < 400 && !done; c++) begin
                to_v = 1'b0;
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) to_v = 1'b1;
                end
                cycle(1, 1, to_v, "loop");
                if (to_v) done = 1'b1;
                if (cmd_delay === 1'b1) begin
                    wait_cnt = int'(delay_n) + 1;
                    dn_run[run] = delay_n;
                end
            end
            check("loop.done", done, 1'b1);
            check("loop.off", data_out, 8'h00);
            check("loop.cmd_once", cmd_seen, 1);
            cycle(0, 0, 0, "loop_idle");
            check("loop.idle", busy, 1'b0);
            if (run > 0) check("loop.dn_differs", dn_run[run] != dn_run[run-1], 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
